// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported backing memory between the
// instruction-fetch port (IF) and the data-memory port (DM).
// Each access occupies the memory for ACCESS_CYCLES cycles (BUSY), followed
// by a one-cycle completion pulse (DONE) and a return to IDLE.
// Optional build macro: MEM_ARB_ROUND_ROBIN_EN -- ties in IDLE alternate
// between the ports; when undefined, DM always wins a tie.
module mem_port_arbiter #(
   parameter int ACCESS_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_ready,
   input  logic        dm_req,
   input  logic        dm_we,
   input  logic [31:0] dm_addr,
   input  logic [31:0] dm_wdata,
   output logic [31:0] dm_rdata,
   output logic        dm_ready,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_we,
   output logic        mem_re,
   input  logic [31:0] mem_rdata,
   output logic        freeze
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   localparam logic [3:0] LAST_CNT = 4'(ACCESS_CYCLES - 1);

   state_t      state_reg, state_next;
   logic        grant_reg, grant_next;   // 0 = IF, 1 = DM
   logic [3:0]  cnt_reg, cnt_next;
   logic [31:0] if_rdata_reg, dm_rdata_reg;
   logic        win_dm;
   logic        cap_if, cap_dm;
   logic        busy;
   logic        granted_we;
   logic        unused_addr_bits;

   // Tie-break: who takes the memory when both ports ask in the same IDLE cycle.
`ifdef MEM_ARB_ROUND_ROBIN_EN
   assign win_dm = dm_req & (~if_req | ~grant_reg);
`else
   assign win_dm = dm_req;
`endif

   // State, grant, cycle counter and read-data registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= IDLE;
         grant_reg    <= 1'b0;
         cnt_reg      <= '0;
         if_rdata_reg <= '0;
         dm_rdata_reg <= '0;
      end else begin
         state_reg <= state_next;
         grant_reg <= grant_next;
         cnt_reg   <= cnt_next;
         if (cap_if) if_rdata_reg <= mem_rdata;
         if (cap_dm) dm_rdata_reg <= mem_rdata;
      end
   end

   // Next-state logic: arbitrate in IDLE, count memory cycles in BUSY,
   // pulse ready in DONE and always fall back to IDLE afterwards.
   always_comb begin
      state_next = state_reg;
      grant_next = grant_reg;
      cnt_next   = cnt_reg;
      cap_if     = 1'b0;
      cap_dm     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (if_req | dm_req) begin
               grant_next = win_dm;
               cnt_next   = '0;
               state_next = BUSY;
            end
         end
         BUSY: begin
            cnt_next = cnt_reg + 4'd1;
            if (cnt_reg == LAST_CNT) begin
               state_next = DONE;
               cap_if     = ~grant_reg;
               cap_dm     = grant_reg & ~dm_we;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Memory-side outputs are live only while BUSY; address/we/wdata come
   // straight from the granted requester, which holds them until ready.
   always_comb begin
      busy       = (state_reg == BUSY);
      granted_we = grant_reg & dm_we;
      mem_addr   = '0;
      mem_wdata  = '0;
      mem_we     = 1'b0;
      mem_re     = 1'b0;
      if (busy) begin
         mem_addr  = {2'b00, (grant_reg ? dm_addr[31:2] : if_addr[31:2])};
         mem_wdata = dm_wdata;
         mem_we    = granted_we;
         mem_re    = ~granted_we;
      end
   end

   // Byte offsets are irrelevant to a word-addressed memory.
   assign unused_addr_bits = ^{if_addr[1:0], dm_addr[1:0]};

   assign if_ready = (state_reg == DONE) & ~grant_reg;
   assign dm_ready = (state_reg == DONE) & grant_reg;
   assign if_rdata = if_rdata_reg;
   assign dm_rdata = dm_rdata_reg;

   // Stall the pipeline while any requester is still waiting for its access.
   assign freeze = (if_req & ~if_ready) | (dm_req & ~dm_ready);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of mem_port_arbiter with a
// 4-cycle instance (dut) and a 1-cycle instance (dut1).
module tb_mem_port_arbiter;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   localparam bit RR_EN = 1'b1;
`else
   localparam bit RR_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic [31:0] if_rdata;
   logic        if_ready;
   logic        dm_req = 1'b0;
   logic        dm_we = 1'b0;
   logic [31:0] dm_addr = '0;
   logic [31:0] dm_wdata = '0;
   logic [31:0] dm_rdata;
   logic        dm_ready;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_we;
   logic        mem_re;
   logic [31:0] mem_rdata;
   logic        freeze;

   logic        u1_if_req = 1'b0;
   logic [31:0] u1_if_addr = '0;
   logic [31:0] u1_if_rdata;
   logic        u1_if_ready;
   logic [31:0] u1_dm_rdata;
   logic        u1_dm_ready;
   logic [31:0] u1_mem_addr;
   logic [31:0] u1_mem_wdata;
   logic        u1_mem_we;
   logic        u1_mem_re;
   logic [31:0] u1_mem_rdata;
   logic        u1_freeze;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   // Backing-memory model: word 4 holds an instruction, others a tagged pattern.
   function automatic logic [31:0] mem_model(input logic [31:0] a);
      return (a == 32'h4) ? 32'hE3A00014 : (a ^ 32'hDEAD0000);
   endfunction

   assign mem_rdata    = mem_model(mem_addr);
   assign u1_mem_rdata = mem_model(u1_mem_addr);

   mem_port_arbiter #(.ACCESS_CYCLES(4)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_rdata(dm_rdata), .dm_ready(dm_ready),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
      .mem_rdata(mem_rdata), .freeze(freeze)
   );

   mem_port_arbiter #(.ACCESS_CYCLES(1)) dut1 (
      .clk(clk), .rst(rst),
      .if_req(u1_if_req), .if_addr(u1_if_addr), .if_rdata(u1_if_rdata), .if_ready(u1_if_ready),
      .dm_req(1'b0), .dm_we(1'b0), .dm_addr(32'h0), .dm_wdata(32'h0),
      .dm_rdata(u1_dm_rdata), .dm_ready(u1_dm_ready),
      .mem_addr(u1_mem_addr), .mem_wdata(u1_mem_wdata), .mem_we(u1_mem_we), .mem_re(u1_mem_re),
      .mem_rdata(u1_mem_rdata), .freeze(u1_freeze)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   initial begin
      int rdy_cnt;
      logic exp_dm;

      // Reset state
      @(negedge clk);
      check("rst_if_rdata", if_rdata, 32'h0);
      check("rst_dm_rdata", dm_rdata, 32'h0);
      check("rst_ready", 32'({if_ready, dm_ready}), 32'h0);
      check("rst_mem_ctl", 32'({mem_we, mem_re}), 32'h0);
      check("rst_mem_addr", mem_addr, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      $display("txn reset done");

      // IF read of 0x10: 4 BUSY cycles at word 4, ready in cycle 5
      @(posedge clk); #1;
      if_req = 1'b1; if_addr = 32'h10;
      @(negedge clk);
      check("if_rd_c0_re", 32'(mem_re), 32'h0);
      check("if_rd_c0_freeze", 32'(freeze), 32'h1);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         check("if_rd_busy_addr", mem_addr, 32'h4);
         check("if_rd_busy_ctl", 32'({mem_re, mem_we, if_ready}), 32'b100);
      end
      @(negedge clk);
      check("if_rd_ready", 32'(if_ready), 32'h1);
      check("if_rd_rdata", if_rdata, 32'hE3A00014);
      check("if_rd_freeze_off", 32'(freeze), 32'h0);
      @(posedge clk); #1;
      if_req = 1'b0;
      @(negedge clk);
      check("if_rd_pulse_end", 32'(if_ready), 32'h0);
      $display("txn if_read addr=0x10 rdata=%h", if_rdata);

      // DM write of 0x2000 to 0x400
      @(posedge clk); #1;
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h400; dm_wdata = 32'h2000;
      @(negedge clk);
      check("dm_wr_c0_we", 32'(mem_we), 32'h0);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         check("dm_wr_busy_addr", mem_addr, 32'h100);
         check("dm_wr_busy_wdata", mem_wdata, 32'h2000);
         check("dm_wr_busy_ctl", 32'({mem_we, mem_re, dm_ready}), 32'b100);
      end
      @(negedge clk);
      check("dm_wr_ready", 32'(dm_ready), 32'h1);
      check("dm_wr_rdata_kept", dm_rdata, 32'h0);
      @(posedge clk); #1;
      dm_req = 1'b0; dm_we = 1'b0;
      @(negedge clk);
      check("dm_wr_pulse_end", 32'(dm_ready), 32'h0);
      $display("txn dm_write addr=0x400 wdata=0x2000");

      // Tie from reset: DM first, IF after one IDLE gap
      do_reset();
      if_req = 1'b1; if_addr = 32'h10;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h400;
      @(negedge clk);
      check("tie_c0_freeze", 32'(freeze), 32'h1);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         check("tie_dm_busy_addr", mem_addr, 32'h100);
         check("tie_freeze", 32'(freeze), 32'h1);
      end
      @(negedge clk);
      check("tie_dm_ready", 32'({dm_ready, if_ready}), 32'b10);
      check("tie_dm_rdata", dm_rdata, 32'hDEAD0100);
      check("tie_freeze_if_wait", 32'(freeze), 32'h1);
      @(posedge clk); #1;
      dm_req = 1'b0;
      @(negedge clk);
      check("tie_gap_idle", 32'({mem_re, mem_we}), 32'h0);
      for (int k = 7; k <= 10; k++) begin
         @(negedge clk);
         check("tie_if_busy_addr", mem_addr, 32'h4);
         check("tie_freeze", 32'(freeze), 32'h1);
      end
      @(negedge clk);
      check("tie_if_ready", 32'({dm_ready, if_ready}), 32'b01);
      check("tie_freeze_off", 32'(freeze), 32'h0);
      @(posedge clk); #1;
      if_req = 1'b0;
      $display("txn tie dm_ready@5 if_ready@11");

      // Both held for 4 accesses
      do_reset();
      if_req = 1'b1; if_addr = 32'h10;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h400;
      for (int n = 0; n < 4; n++) begin
         rdy_cnt = 0;
         for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (if_ready | dm_ready) rdy_cnt++;
         end
         check("hold_no_early_ready", 32'(rdy_cnt), 32'h0);
         @(negedge clk);
         exp_dm = RR_EN ? ((n % 2) == 0) : 1'b1;
         check("hold_winner", 32'({dm_ready, if_ready}), 32'({exp_dm, ~exp_dm}));
         $display("txn hold access=%0d dm_ready=%0d if_ready=%0d", n, dm_ready, if_ready);
      end
      @(posedge clk); #1;
      if_req = 1'b0; dm_req = 1'b0;

      // Reset in the 2nd BUSY cycle of a write
      @(posedge clk); #1;
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h400; dm_wdata = 32'h55;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      check("rstw_busy_we", 32'(mem_we), 32'h1);
      #2;
      rst = 1'b1;
      #1;
      check("rstw_we_drop", 32'({mem_we, mem_re}), 32'h0);
      check("rstw_addr", mem_addr, 32'h0);
      check("rstw_if_rdata", if_rdata, 32'h0);
      check("rstw_dm_rdata", dm_rdata, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
      rdy_cnt = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (dm_ready | if_ready | mem_we | mem_re) rdy_cnt++;
      end
      check("rstw_no_ready", 32'(rdy_cnt), 32'h0);
      $display("txn reset_mid_write aborted");

      // ACCESS_CYCLES=1 read on dut1
      @(posedge clk); #1;
      u1_if_req = 1'b1; u1_if_addr = 32'h10;
      @(negedge clk);
      check("ac1_c0_ready", 32'(u1_if_ready), 32'h0);
      @(negedge clk);
      check("ac1_busy_addr", u1_mem_addr, 32'h4);
      check("ac1_busy_re", 32'(u1_mem_re), 32'h1);
      @(negedge clk);
      check("ac1_ready", 32'(u1_if_ready), 32'h1);
      check("ac1_rdata", u1_if_rdata, 32'hE3A00014);
      @(posedge clk); #1;
      u1_if_req = 1'b0;
      $display("txn ac1_if_read rdata=%h", u1_if_rdata);

      // IF request dropped mid-BUSY still completes
      @(posedge clk); #1;
      if_req = 1'b1; if_addr = 32'h20;
      @(negedge clk);
      @(negedge clk);
      check("drop_busy_addr", mem_addr, 32'h8);
      @(posedge clk); #1;
      if_req = 1'b0;
      for (int k = 2; k <= 4; k++) begin
         @(negedge clk);
         check("drop_busy_re", 32'({mem_re, if_ready}), 32'b10);
      end
      @(negedge clk);
      check("drop_ready", 32'(if_ready), 32'h1);
      check("drop_rdata", if_rdata, 32'hDEAD0008);
      @(negedge clk);
      check("drop_pulse_end", 32'(if_ready), 32'h0);
      $display("txn if_read_dropped addr=0x20 rdata=%h", if_rdata);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #100000;
      failures++;
      $display("FAIL watchdog got=timeout exp=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
